// File: rtl/div_hilo_ctrl_pkg.sv
// Shared op codes, FSM state encoding and constants for the EX-stage
// multiply/divide control unit.
package div_hilo_ctrl_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  localparam logic [31:0] ZERO32 = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/div_hilo_ctrl.sv
// Divide/MTHI/MTLO control: issues operands to the external divider, stalls the
// pipeline until it answers, and owns the architectural HI/LO registers.
module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 40,
  parameter logic [31:0] HI_RST       = 32'h0,
  parameter logic [31:0] LO_RST       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_sel_o,
  output logic        div_sign_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  input  logic [63:0] div_result_i,
  input  logic        div_valid_i
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [31:0]    hi_reg;
  logic [31:0]    lo_reg;
  logic [31:0]    dividend_reg;
  logic [31:0]    divisor_reg;
  logic [63:0]    result_reg;
  logic           sel_reg;
  logic           sign_reg;
  logic           done_reg;

  logic is_div;
  logic div_req;
  logic mt_ok;

  assign is_div  = op_valid_i && ((op_i == OP_DIV) || (op_i == OP_DIVU));
  assign div_req = is_div && !flush_i;
  assign mt_ok   = op_valid_i && !flush_i && ((state_reg == S_IDLE) || (state_reg == S_DRAIN));

  // Stall must rise in the accept cycle itself, so it is decoded from state.
  always_comb begin
    stall_o = 1'b0;
    unique case (state_reg)
      S_IDLE:  stall_o = div_req;
      S_BUSY:  stall_o = 1'b1;
      S_DONE:  stall_o = 1'b0;
      S_DRAIN: stall_o = is_div;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Stale divider output may still arrive after a mid-op reset.
      state_reg    <= S_DRAIN;
      cnt_reg      <= CW'(DRAIN_CYCLES);
      hi_reg       <= HI_RST;
      lo_reg       <= LO_RST;
      dividend_reg <= ZERO32;
      divisor_reg  <= ZERO32;
      result_reg   <= {ZERO32, ZERO32};
      sel_reg      <= 1'b0;
      sign_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        S_IDLE: begin
          if (div_req) begin
            dividend_reg <= rs_i;
            divisor_reg  <= rt_i;
            sign_reg     <= (op_i == OP_DIV);
            if (rt_i != ZERO32) begin
              sel_reg   <= 1'b1;
              state_reg <= S_BUSY;
            end else begin
              // Divide by zero never reaches the divider; commit leaves HI/LO as is.
              result_reg <= {lo_reg, hi_reg};
              done_reg   <= 1'b1;
              state_reg  <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            sel_reg   <= 1'b0;
            cnt_reg   <= CW'(DRAIN_CYCLES);
            state_reg <= S_DRAIN;
          end else if (div_valid_i) begin
            result_reg <= div_result_i;
            sel_reg    <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!flush_i) begin
            lo_reg <= result_reg[63:32];
            hi_reg <= result_reg[31:0];
          end
          state_reg <= S_IDLE;
        end
        S_DRAIN: begin
          if (cnt_reg <= CW'(1)) begin
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: state_reg <= S_DRAIN;
      endcase

      if (mt_ok) begin
        if (op_i == OP_MTHI) hi_reg <= rs_i;
        if (op_i == OP_MTLO) lo_reg <= rs_i;
      end
    end
  end

  assign done_o         = done_reg;
  assign hi_o           = hi_reg;
  assign lo_o           = lo_reg;
  assign div_sel_o      = sel_reg;
  assign div_sign_o     = sign_reg;
  assign div_dividend_o = dividend_reg;
  assign div_divisor_o  = divisor_reg;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a fixed-latency divider model alongside.
module tb_div_hilo_ctrl;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = 32'h0;
  logic [31:0] rt = 32'h0;
  logic        flush = 1'b0;
  logic        stall, done, sel, sign;
  logic [31:0] hi, lo, dividend, divisor;
  logic [63:0] div_result;
  logic        div_valid;
  logic        inject = 1'b0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  div_hilo_ctrl #(.DRAIN_CYCLES(40), .HI_RST(32'h0), .LO_RST(32'h0)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_i(op), .rs_i(rs), .rt_i(rt),
    .flush_i(flush), .stall_o(stall), .done_o(done), .hi_o(hi), .lo_o(lo),
    .div_sel_o(sel), .div_sign_o(sign), .div_dividend_o(dividend),
    .div_divisor_o(divisor), .div_result_i(div_result), .div_valid_i(div_valid)
  );

  // Divider model: out_valid rises LAT cycles after sel is first seen, clears when sel drops.
  int   mcnt = 0;
  logic mvalid = 1'b0;
  logic [31:0] mq, mr;

  always @(posedge clk) begin
    if (!sel) begin
      mcnt   <= 0;
      mvalid <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt == LAT - 1) mvalid <= 1'b1;
    end
  end

  always_comb begin
    mq = 32'h0;
    mr = 32'h0;
    if (divisor != 32'h0) begin
      if (sign) begin
        if (dividend == 32'h80000000 && divisor == 32'hFFFFFFFF) begin
          mq = 32'h80000000;
          mr = 32'h0;
        end else begin
          mq = $signed(dividend) / $signed(divisor);
          mr = $signed(dividend) % $signed(divisor);
        end
      end else begin
        mq = dividend / divisor;
        mr = dividend % divisor;
      end
    end
  end

  assign div_valid  = mvalid | inject;
  assign div_result = inject ? 64'hDEADBEEF_CAFEF00D : {mq, mr};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op and hold it while the pipeline is stalled; returns at the
  // cycle after the first non-stalled cycle, with op_valid dropped.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int inject_at, output int stalls, output int sels,
                       output logic sign_any, output logic sign_all, output int opnd_bad,
                       output logic done_seen, output logic sel_at_done);
    logic finished;
    op_valid = 1'b1; op = o; rs = a; rt = b;
    stalls = 0; sels = 0; sign_any = 1'b0; sign_all = 1'b1; opnd_bad = 0;
    done_seen = 1'b0; sel_at_done = 1'b1; finished = 1'b0;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (!stall) begin
        done_seen   = done;
        sel_at_done = sel;
        finished    = 1'b1;
        break;
      end
      stalls++;
      if (sel) begin
        sels++;
        sign_any = sign_any | sign;
        sign_all = sign_all & sign;
        if (dividend !== a || divisor !== b) opnd_bad++;
      end
      inject = (n == inject_at);
      @(posedge clk); #1;
    end
    inject = 1'b0;
    chk("op_timeout", {63'h0, finished}, 64'h1);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic div_case(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at, input int exp_stalls,
                          input int exp_sels, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int st, se, ob;
    logic sa, sl, dn, sd;
    do_op(o, a, b, inject_at, st, se, sa, sl, ob, dn, sd);
    chk({tag, "_stalls"}, 64'(st), 64'(exp_stalls));
    chk({tag, "_sel_cycles"}, 64'(se), 64'(exp_sels));
    chk({tag, "_done_pulse"}, {63'h0, dn}, 64'h1);
    chk({tag, "_sel_low_at_done"}, {63'h0, sd}, 64'h0);
    if (exp_sels != 0) begin
      chk({tag, "_operands_stable"}, 64'(ob), 64'h0);
      if (o == 3'd1) chk({tag, "_sign_div"}, {63'h0, sl}, 64'h1);
      else           chk({tag, "_sign_divu"}, {63'h0, sa}, 64'h0);
    end
    #1;
    chk({tag, "_done_one_cycle"}, {63'h0, done}, 64'h0);
    chk({tag, "_lo"}, {32'h0, lo}, {32'h0, exp_lo});
    chk({tag, "_hi"}, {32'h0, hi}, {32'h0, exp_hi});
    $display("txn %s rs=%h rt=%h stalls=%0d sel_cycles=%0d lo=%h hi=%h", tag, a, b, st, se, lo, hi);
  endtask

  task automatic mt_op(input string tag, input logic [2:0] o, input logic [31:0] v);
    op_valid = 1'b1; op = o; rs = v;
    #1;
    chk({tag, "_no_stall"}, {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    #1;
    if (o == 3'd3) chk({tag, "_hi"}, {32'h0, hi}, {32'h0, v});
    else           chk({tag, "_lo"}, {32'h0, lo}, {32'h0, v});
    $display("txn %s value=%h hi=%h lo=%h", tag, v, hi, lo);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    chk("rst_sel", {63'h0, sel}, 64'h0);
    chk("rst_sign", {63'h0, sign}, 64'h0);
    chk("rst_dividend", {32'h0, dividend}, 64'h0);
    chk("rst_divisor", {32'h0, divisor}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_stall", {63'h0, stall}, 64'h0);
    $display("txn reset hi=%h lo=%h", hi, lo);
    rst = 1'b0;
    repeat (45) @(posedge clk);
    #1;

    // Signed and unsigned divides: accept cycle + 35 BUSY cycles stalled
    div_case("div_neg7_by_2", 3'd1, 32'hFFFFFFF9, 32'h2, -1, 36, 35, 32'hFFFFFFFD, 32'hFFFFFFFF);
    div_case("divu_max_by_16", 3'd2, 32'hFFFFFFFF, 32'h10, -1, 36, 35, 32'h0FFFFFFF, 32'h0000000F);

    // MTHI/MTLO then divide by zero leaves HI/LO untouched
    mt_op("mthi", 3'd3, 32'h1234);
    mt_op("mtlo", 3'd4, 32'h5678);
    div_case("div_by_zero", 3'd1, 32'h99, 32'h0, -1, 1, 0, 32'h5678, 32'h1234);

    // Flush during BUSY cycle 5
    op_valid = 1'b1; op = 3'd1; rs = 32'd100; rt = 32'd7;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 5) begin
        chk("flush_in_busy_sel", {63'h0, sel}, 64'h1);
        flush = 1'b1;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; op_valid = 1'b0; op = 3'd0;
    #1;
    chk("flush_sel_drop", {63'h0, sel}, 64'h0);
    chk("flush_hi_kept", {32'h0, hi}, 64'h1234);
    chk("flush_lo_kept", {32'h0, lo}, 64'h5678);
    $display("txn flush_busy sel=%b hi=%h lo=%h", sel, hi, lo);
    // DIV held through DRAIN (40 cycles) + accept + 35 BUSY; stale pulse injected
    div_case("div_after_drain", 3'd1, 32'd200, 32'd9, 3, 76, 35, 32'd22, 32'd2);

    // Back-to-back divides commit in order
    div_case("b2b_first", 3'd1, 32'd1000, 32'd10, -1, 36, 35, 32'd100, 32'd0);
    div_case("b2b_second", 3'd1, 32'hFFFFFF9C, 32'd7, -1, 36, 35, 32'hFFFFFFF2, 32'hFFFFFFFE);

    // Reset asserted mid-BUSY
    op_valid = 1'b1; op = 3'd1; rs = 32'd50; rt = 32'd5;
    repeat (10) begin
      @(posedge clk); #1;
    end
    #1;
    chk("midrst_busy_sel", {63'h0, sel}, 64'h1);
    rst = 1'b1; op_valid = 1'b0; op = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_sel", {63'h0, sel}, 64'h0);
    chk("midrst_hi", {32'h0, hi}, 64'h0);
    chk("midrst_lo", {32'h0, lo}, 64'h0);
    chk("midrst_dividend", {32'h0, dividend}, 64'h0);
    chk("midrst_stall", {63'h0, stall}, 64'h0);
    $display("txn mid_busy_reset sel=%b hi=%h lo=%h", sel, hi, lo);
    mt_op("mtlo_in_drain", 3'd4, 32'hABCD);
    op_valid = 1'b1; op = 3'd1; rs = 32'd8; rt = 32'd2;
    #1;
    chk("drain_div_stall", {63'h0, stall}, 64'h1);
    @(posedge clk); #1;
    chk("drain_div_not_issued", {63'h0, sel}, 64'h0);
    op_valid = 1'b0; op = 3'd0;
    $display("txn div_in_drain stall=%b sel=%b", stall, sel);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
